// File: rtl/me_wb_lane_stage.sv
// me_wb_lane_stage: ME -> WB pipeline stage for LANES issue lanes.
// Two-entry elastic buffer (head + skid) with registered in_ready,
// synchronous flush, bubble squashing and write-data select at capture.
module me_wb_lane_stage #(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int RIDX  = 5
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    FLUSH,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_lane_valid,
    input  logic [LANES-1:0]        in_regwrite,
    input  logic [LANES*RIDX-1:0]   in_rd,
    input  logic [LANES*2-1:0]      in_rfwt_sel,
    input  logic [LANES*XLEN-1:0]   in_alu,
    input  logic [LANES*XLEN-1:0]   in_memdat,
    input  logic [LANES*XLEN-1:0]   in_pc,
    input  logic                    in_order,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_lane_valid,
    output logic [LANES-1:0]        out_we,
    output logic [LANES*RIDX-1:0]   out_rd,
    output logic [LANES*XLEN-1:0]   out_wdata,
    output logic [LANES*XLEN-1:0]   out_pc,
    output logic                    out_order
);

    localparam int LR = LANES * RIDX;
    localparam int LW = LANES * XLEN;

    // One buffered bundle; wdata is already the final register-file value.
    typedef struct packed {
        logic [LANES-1:0] lv;
        logic [LANES-1:0] rw;
        logic [LR-1:0]    rd;
        logic [LW-1:0]    wd;
        logic [LW-1:0]    pc;
        logic             ord;
    } entry_t;

    // Register-file write source: 1 = load data, 2 = link address, else ALU.
    function automatic logic [XLEN-1:0] sel_wdata(input logic [1:0]      sel,
                                                  input logic [XLEN-1:0] alu,
                                                  input logic [XLEN-1:0] mem,
                                                  input logic [XLEN-1:0] pc);
        logic [XLEN-1:0] r;
        case (sel)
            2'd1:    r = mem;
            2'd2:    r = pc + {{(XLEN-3){1'b0}}, 3'd4};
            default: r = alu;
        endcase
        return r;
    endfunction

    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t new_e;
    logic   head_v_q, head_v_d;
    logic   skid_v_q, skid_v_d;
    logic   in_ready_q, in_ready_d;
    logic   accept;
    logic   store;
    logic   retire;

    assign accept = in_valid & in_ready_q;
    // All-invalid bundles are handshaken but never occupy an entry.
    assign store  = accept & (|in_lane_valid);
    assign retire = head_v_q & out_ready;

    // Build the entry for the incoming bundle, selecting write data per lane.
    always_comb begin
        new_e     = '0;
        new_e.lv  = in_lane_valid;
        new_e.rw  = in_regwrite;
        new_e.rd  = in_rd;
        new_e.pc  = in_pc;
        new_e.ord = in_order;
        for (int i = 0; i < LANES; i++) begin
            new_e.wd[i*XLEN +: XLEN] = sel_wdata(in_rfwt_sel[i*2 +: 2],
                                                 in_alu[i*XLEN +: XLEN],
                                                 in_memdat[i*XLEN +: XLEN],
                                                 in_pc[i*XLEN +: XLEN]);
        end
    end

    // Next-state of head/skid: flush first, then refill head, else park in skid.
    always_comb begin
        head_d   = head_q;
        skid_d   = skid_q;
        head_v_d = head_v_q;
        skid_v_d = skid_v_q;
        if (FLUSH) begin
            head_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!head_v_q || retire) begin
            if (skid_v_q) begin
                // Skid promotes; a new bundle (only possible if ready was
                // high) then takes the skid so nothing is dropped.
                head_d   = skid_q;
                head_v_d = 1'b1;
                skid_v_d = store;
                if (store) begin
                    skid_d = new_e;
                end
            end else begin
                head_v_d = store;
                if (store) begin
                    head_d = new_e;
                end
            end
        end else if (store) begin
            skid_d   = new_e;
            skid_v_d = 1'b1;
        end
        in_ready_d = !skid_v_d;
    end

    // State registers; data is reset too so out_* read zero out of reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head_q     <= '0;
            skid_q     <= '0;
            head_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            head_q     <= head_d;
            skid_q     <= skid_d;
            head_v_q   <= head_v_d;
            skid_v_q   <= skid_v_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Write enables are masked by head presence so flushed data never writes.
    always_comb begin
        out_we = '0;
        for (int i = 0; i < LANES; i++) begin
            out_we[i] = head_v_q & head_q.lv[i] & head_q.rw[i]
                        & (head_q.rd[i*RIDX +: RIDX] != '0);
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = head_v_q;
    assign out_lane_valid = head_q.lv & {LANES{head_v_q}};
    assign out_rd         = head_q.rd;
    assign out_wdata      = head_q.wd;
    assign out_pc         = head_q.pc;
    assign out_order      = head_q.ord;

endmodule

// File: tb/tb_me_wb_lane_stage.sv
// Scoreboard bench for me_wb_lane_stage (LANES=2, XLEN=32, RIDX=5).
module tb_me_wb_lane_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        FLUSH;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_lane_valid;
    logic [1:0]  in_regwrite;
    logic [9:0]  in_rd;
    logic [3:0]  in_rfwt_sel;
    logic [63:0] in_alu;
    logic [63:0] in_memdat;
    logic [63:0] in_pc;
    logic        in_order;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_lane_valid;
    logic [1:0]  out_we;
    logic [9:0]  out_rd;
    logic [63:0] out_wdata;
    logic [63:0] out_pc;
    logic        out_order;

    typedef struct {
        logic [1:0]  lv;
        logic [1:0]  we;
        logic [9:0]  rd;
        logic [63:0] wd;
        logic [63:0] pc;
        logic        ord;
    } exp_t;

    exp_t q[$];
    exp_t cur_exp;
    int   checks   = 0;
    int   failures = 0;

    me_wb_lane_stage #(.LANES(2), .XLEN(32), .RIDX(5)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_valid(in_lane_valid), .in_regwrite(in_regwrite),
        .in_rd(in_rd), .in_rfwt_sel(in_rfwt_sel),
        .in_alu(in_alu), .in_memdat(in_memdat), .in_pc(in_pc),
        .in_order(in_order),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lane_valid(out_lane_valid), .out_we(out_we),
        .out_rd(out_rd), .out_wdata(out_wdata), .out_pc(out_pc),
        .out_order(out_order)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Offer a bundle; expected lv/rd/pc/order follow the inputs, we/wdata are hand values.
    task automatic drive(input logic [1:0] lv, input logic [1:0] rw,
                         input logic [4:0] rd1, input logic [4:0] rd0,
                         input logic [1:0] s1, input logic [1:0] s0,
                         input logic [31:0] a1, input logic [31:0] a0,
                         input logic [31:0] m1, input logic [31:0] m0,
                         input logic [31:0] p1, input logic [31:0] p0,
                         input logic ord, input logic [1:0] ewe,
                         input logic [31:0] ew1, input logic [31:0] ew0);
        in_valid      = 1'b1;
        in_lane_valid = lv;
        in_regwrite   = rw;
        in_rd         = {rd1, rd0};
        in_rfwt_sel   = {s1, s0};
        in_alu        = {a1, a0};
        in_memdat     = {m1, m0};
        in_pc         = {p1, p0};
        in_order      = ord;
        cur_exp.lv    = lv;
        cur_exp.we    = ewe;
        cur_exp.rd    = {rd1, rd0};
        cur_exp.wd    = {ew1, ew0};
        cur_exp.pc    = {p1, p0};
        cur_exp.ord   = ord;
    endtask

    task automatic idle();
        in_valid      = 1'b0;
        in_lane_valid = 2'b00;
    endtask

    // One cycle; records the expected bundle if the coming edge accepts and stores it.
    task automatic tick();
        @(negedge CLK);
        if (in_valid && in_ready && (in_lane_valid != 2'b00) && !FLUSH)
            q.push_back(cur_exp);
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every consumed head bundle is compared against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mon_unexpected actual_pc=%0h required=none", out_pc);
                end else begin
                    e = q.pop_front();
                    chk("mon_lane_valid", out_lane_valid, e.lv);
                    chk("mon_we", out_we, e.we);
                    chk("mon_rd", out_rd, e.rd);
                    chk("mon_wdata", out_wdata, e.wd);
                    chk("mon_pc", out_pc, e.pc);
                    chk("mon_order", out_order, e.ord);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; FLUSH = 1'b0; out_ready = 1'b0;
        in_regwrite = '0; in_rd = '0; in_rfwt_sel = '0;
        in_alu = '0; in_memdat = '0; in_pc = '0; in_order = 1'b0;
        cur_exp = '{default: '0};
        idle();
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_lane_valid", out_lane_valid, 0);
        chk("rst_we", out_we, 0);
        chk("rst_rd", out_rd, 0);
        chk("rst_wdata", out_wdata, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_order", out_order, 0);
        @(posedge CLK); @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;

        // Pass-through and write-data select
        out_ready = 1'b1;
        drive(2'b11, 2'b11, 5'd7, 5'd3, 2'd2, 2'd0, 32'h0, 32'h11, 32'h0, 32'h0,
              32'h100, 32'h0, 1'b0, 2'b11, 32'h104, 32'h11);
        tick();
        chk("pt_out_valid", out_valid, 1);
        chk("pt_we", out_we, 2'b11);
        chk("pt_wdata", out_wdata, {32'h104, 32'h11});
        drive(2'b11, 2'b01, 5'd5, 5'd0, 2'd3, 2'd1, 32'h55, 32'h0, 32'h0, 32'hDEAD,
              32'h14, 32'h10, 1'b0, 2'b00, 32'h55, 32'hDEAD);
        tick();
        drive(2'b01, 2'b11, 5'd9, 5'd4, 2'd0, 2'd2, 32'h77, 32'h0, 32'h0, 32'h0,
              32'h0, 32'hFFFF_FFFC, 1'b1, 2'b01, 32'h77, 32'h0);
        tick();
        idle();
        tick(); tick();
        chk("pt_drained", out_valid, 0);

        // Back-pressure: A head, B skid, C refused until recovery
        out_ready = 1'b0;
        drive(2'b11, 2'b11, 5'd2, 5'd1, 2'd1, 2'd0, 32'h0, 32'hA0, 32'hA1, 32'h0,
              32'h204, 32'h200, 1'b0, 2'b11, 32'hA1, 32'hA0);
        tick();
        drive(2'b10, 2'b10, 5'd6, 5'd0, 2'd2, 2'd0, 32'h0, 32'hB0, 32'h0, 32'h0,
              32'h304, 32'h300, 1'b1, 2'b10, 32'h308, 32'hB0);
        tick();
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_head_a", out_pc[31:0], 32'h200);
        drive(2'b11, 2'b01, 5'd9, 5'd8, 2'd0, 2'd3, 32'hC1, 32'hC0, 32'h0, 32'h0,
              32'h404, 32'h400, 1'b0, 2'b01, 32'hC1, 32'hC0);
        tick();
        chk("bp_c_refused", in_ready, 0);
        chk("bp_head_held", out_wdata, {32'hA1, 32'hA0});
        out_ready = 1'b1;
        tick();
        chk("bp_recover_ready", in_ready, 1);
        chk("bp_head_b", out_pc[31:0], 32'h300);
        tick();
        idle();
        chk("bp_head_c_valid", out_valid, 1);
        chk("bp_head_c", out_pc[31:0], 32'h400);
        tick(); tick();

        // Bubble squash
        drive(2'b00, 2'b11, 5'd1, 5'd1, 2'd0, 2'd0, 32'h1, 32'h1, 32'h0, 32'h0,
              32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        idle();
        chk("bub_in_ready", in_ready, 1);
        chk("bub_out_valid", out_valid, 0);

        // Flush with retire and accept: D retires, F is discarded
        out_ready = 1'b0;
        drive(2'b01, 2'b01, 5'd0, 5'd10, 2'd0, 2'd0, 32'h0, 32'hD0, 32'h0, 32'h0,
              32'h0, 32'h500, 1'b1, 2'b01, 32'h0, 32'hD0);
        tick();
        out_ready = 1'b1;
        FLUSH = 1'b1;
        drive(2'b11, 2'b11, 5'd11, 5'd12, 2'd0, 2'd0, 32'hF1, 32'hF0, 32'h0, 32'h0,
              32'h604, 32'h600, 1'b0, 2'b11, 32'hF1, 32'hF0);
        tick();
        FLUSH = 1'b0;
        idle();
        chk("fl1_out_valid", out_valid, 0);
        chk("fl1_in_ready", in_ready, 1);

        // Flush with head and skid full plus an offered bundle
        out_ready = 1'b0;
        drive(2'b01, 2'b01, 5'd0, 5'd13, 2'd0, 2'd0, 32'h0, 32'hD2, 32'h0, 32'h0,
              32'h0, 32'h700, 1'b0, 2'b01, 32'h0, 32'hD2);
        tick();
        drive(2'b01, 2'b01, 5'd0, 5'd14, 2'd0, 2'd0, 32'h0, 32'hE0, 32'h0, 32'h0,
              32'h0, 32'h800, 1'b0, 2'b01, 32'h0, 32'hE0);
        tick();
        chk("fl2_full", in_ready, 0);
        FLUSH = 1'b1;
        drive(2'b11, 2'b11, 5'd15, 5'd16, 2'd0, 2'd0, 32'hF3, 32'hF2, 32'h0, 32'h0,
              32'h904, 32'h900, 1'b0, 2'b11, 32'hF3, 32'hF2);
        tick();
        FLUSH = 1'b0;
        idle();
        q.delete();
        chk("fl2_out_valid", out_valid, 0);
        chk("fl2_in_ready", in_ready, 1);
        out_ready = 1'b1;
        tick(); tick();
        chk("fl2_nothing_late", out_valid, 0);

        // Asynchronous reset between edges
        out_ready = 1'b0;
        drive(2'b11, 2'b11, 5'd17, 5'd18, 2'd0, 2'd0, 32'h21, 32'h20, 32'h0, 32'h0,
              32'hA04, 32'hA00, 1'b1, 2'b11, 32'h21, 32'h20);
        tick();
        idle();
        chk("ar_loaded", out_valid, 1);
        #2;
        RST = 1'b1;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_we", out_we, 0);
        chk("ar_in_ready", in_ready, 1);
        q.delete();
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
        out_ready = 1'b1;
        drive(2'b10, 2'b10, 5'd19, 5'd0, 2'd1, 2'd0, 32'h0, 32'h0, 32'h31, 32'h0,
              32'hB04, 32'hB00, 1'b0, 2'b10, 32'h31, 32'h0);
        tick();
        idle();
        tick(); tick();

        chk("sb_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
